fm_discriminator: RTL and testbench

//  Multi-channel FM phase discriminator, parametrised successor to the single-channel demodulator.

---
 rtl/fmd_pkg.sv | 26 ++
 rtl/fm_discriminator_if.sv | 32 +++
 rtl/fmd_deemph.sv | 52 +++++
 rtl/fm_discriminator.sv | 164 ++++++++++++++++
 tb/tb_fm_discriminator.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fmd_pkg.sv
// ============================================================================
//  Module      : fmd_pkg
//  Description : Shared types, default sizes and helpers for fm_discriminator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fmd_pkg;

  localparam int FMD_PHASE_W = 16;
  localparam int FMD_NUM_CH  = 4;

  typedef logic signed [FMD_PHASE_W-1:0] phase_t;

  // Modular subtraction: the result read as signed is the shortest rotation.
  function automatic phase_t phase_diff(input phase_t a, input phase_t b);
    return a - b;
  endfunction

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fm_discriminator_if.sv
// ============================================================================
//  Module      : fm_discriminator_if
//  Description : AXI-Stream bundle with channel-index tuser.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fm_discriminator_if #(
  parameter int DATA_W = 32,
  parameter int USER_W = 1
);

  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;
  logic                  tlast;
  logic [USER_W-1:0]     tuser;

  modport master (
    output tvalid, tdata, tstrb, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tlast, tuser,
    output tready
  );

endinterface

`default_nettype wire

// File: rtl/fmd_deemph.sv
// ============================================================================
//  Module      : fmd_deemph
//  Description : Per-channel one-pole IIR, y += (x - y) >>> DEEMPH_SHIFT.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fmd_deemph #(
  parameter int PHASE_W      = 16,
  parameter int NUM_CH       = 4,
  parameter int CH_W         = 2,
  parameter int DEEMPH_SHIFT = 4
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               i_en,
  input  wire logic [CH_W-1:0]    i_ch,
  input  wire logic [PHASE_W-1:0] i_d,
  output logic      [PHASE_W-1:0] o_y
);

  localparam int ACC_W = PHASE_W + DEEMPH_SHIFT;

  logic signed [ACC_W-1:0] r_y [NUM_CH];
  logic signed [ACC_W-1:0] w_y_cur;
  logic signed [ACC_W-1:0] w_x;
  logic signed [ACC_W:0]   w_err;
  logic signed [ACC_W:0]   w_step;
  logic signed [ACC_W-1:0] w_y_next;

  assign w_y_cur = r_y[i_ch];
  assign w_x     = {i_d, {DEEMPH_SHIFT{1'b0}}};

  // One guard bit so x - y cannot overflow; the shifted step fits back in ACC_W.
  assign w_err    = $signed({w_x[ACC_W-1], w_x}) - $signed({w_y_cur[ACC_W-1], w_y_cur});
  assign w_step   = w_err >>> DEEMPH_SHIFT;
  assign w_y_next = w_y_cur + w_step[ACC_W-1:0];
  assign o_y      = w_y_next[ACC_W-1 -: PHASE_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_y[i] <= '0;
      end
    end else if (i_en) begin
      r_y[i_ch] <= w_y_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fm_discriminator.sv
// ============================================================================
//  Module      : fm_discriminator
//  Description : Multi-channel FM phase discriminator, optional squelch and
//                de-emphasis (enable with macro FMD_DEEMPH_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fm_discriminator
  import fmd_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int PHASE_W                = FMD_PHASE_W,
  parameter int NUM_CH                 = FMD_NUM_CH,
  parameter int DEEMPH_SHIFT           = 4
) (
  input  wire logic          s00_axis_aclk,
  input  wire logic          s00_axis_areset,
  fm_discriminator_if.slave  s00_axis,
  fm_discriminator_if.master m00_axis,
  input  wire logic [15:0]   squelch_thresh
);

  localparam int CH_W     = ch_width(NUM_CH);
  localparam int S_STRB_W = C_S00_AXIS_TDATA_WIDTH / 8;
  localparam int M_STRB_W = C_M00_AXIS_TDATA_WIDTH / 8;

  logic                w_adv;
  logic                w_accept;
  logic [PHASE_W-1:0]  w_angle;
  logic [15:0]         w_mag;
  logic [PHASE_W-1:0]  w_prev;
  logic [PHASE_W-1:0]  w_raw;
  logic [PHASE_W-1:0]  w_d;
  logic                w_unused_ok;

  logic [CH_W-1:0]     r_ch_cnt;
  logic [PHASE_W-1:0]  r_prev_angle [NUM_CH];
  logic [NUM_CH-1:0]   r_primed;

  logic                r_s1_valid;
  logic [PHASE_W-1:0]  r_s1_d;
  logic [CH_W-1:0]     r_s1_user;
  logic                r_s1_last;
  logic [S_STRB_W-1:0] r_s1_strb;

  logic                w_out_valid;
  logic [PHASE_W-1:0]  w_out_d;
  logic [CH_W-1:0]     w_out_user;
  logic                w_out_last;
  logic [S_STRB_W-1:0] w_out_strb;

  assign w_adv           = ~m00_axis.tvalid | m00_axis.tready;
  assign s00_axis.tready = w_adv;
  assign w_accept        = s00_axis.tvalid & w_adv;

  assign w_angle = s00_axis.tdata[C_S00_AXIS_TDATA_WIDTH-1 -: PHASE_W];
  assign w_mag   = s00_axis.tdata[15:0];
  assign w_prev  = r_prev_angle[r_ch_cnt];

  if (PHASE_W == FMD_PHASE_W) begin : g_diff_pkg
    assign w_raw = phase_diff(w_angle, w_prev);
  end else begin : g_diff_generic
    assign w_raw = w_angle - w_prev;
  end

  // A zero threshold can never exceed the magnitude, so squelch disables itself.
  assign w_d = (!r_primed[r_ch_cnt] || (w_mag < squelch_thresh)) ? '0 : w_raw;

  assign w_unused_ok = &{1'b0, s00_axis.tuser, s00_axis.tdata};

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      r_ch_cnt   <= '0;
      r_primed   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_prev_angle[i] <= '0;
      end
      r_s1_valid <= 1'b0;
      r_s1_d     <= '0;
      r_s1_user  <= '0;
      r_s1_last  <= 1'b0;
      r_s1_strb  <= '0;
    end else if (w_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        if (s00_axis.tlast || (r_ch_cnt == CH_W'(NUM_CH - 1))) begin
          r_ch_cnt <= '0;
        end else begin
          r_ch_cnt <= r_ch_cnt + 1'b1;
        end
        r_primed[r_ch_cnt]     <= 1'b1;
        r_prev_angle[r_ch_cnt] <= w_angle;
        r_s1_d                 <= w_d;
        r_s1_user              <= r_ch_cnt;
        r_s1_last              <= s00_axis.tlast;
        r_s1_strb              <= s00_axis.tstrb;
      end
    end
  end

`ifdef FMD_DEEMPH_EN
  logic                r_s2_valid;
  logic [PHASE_W-1:0]  r_s2_d;
  logic [CH_W-1:0]     r_s2_user;
  logic                r_s2_last;
  logic [S_STRB_W-1:0] r_s2_strb;
  logic [PHASE_W-1:0]  w_y;

  fmd_deemph #(
    .PHASE_W      (PHASE_W),
    .NUM_CH       (NUM_CH),
    .CH_W         (CH_W),
    .DEEMPH_SHIFT (DEEMPH_SHIFT)
  ) u_deemph (
    .clk  (s00_axis_aclk),
    .rst  (s00_axis_areset),
    .i_en (w_adv & r_s1_valid),
    .i_ch (r_s1_user),
    .i_d  (r_s1_d),
    .o_y  (w_y)
  );

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      r_s2_valid <= 1'b0;
      r_s2_d     <= '0;
      r_s2_user  <= '0;
      r_s2_last  <= 1'b0;
      r_s2_strb  <= '0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_d    <= w_y;
        r_s2_user <= r_s1_user;
        r_s2_last <= r_s1_last;
        r_s2_strb <= r_s1_strb;
      end
    end
  end

  assign w_out_valid = r_s2_valid;
  assign w_out_d     = r_s2_d;
  assign w_out_user  = r_s2_user;
  assign w_out_last  = r_s2_last;
  assign w_out_strb  = r_s2_strb;
`else
  assign w_out_valid = r_s1_valid;
  assign w_out_d     = r_s1_d;
  assign w_out_user  = r_s1_user;
  assign w_out_last  = r_s1_last;
  assign w_out_strb  = r_s1_strb;
`endif

  assign m00_axis.tvalid = w_out_valid;
  assign m00_axis.tdata  = {{(C_M00_AXIS_TDATA_WIDTH - PHASE_W){w_out_d[PHASE_W-1]}}, w_out_d};
  assign m00_axis.tstrb  = M_STRB_W'(w_out_strb);
  assign m00_axis.tlast  = w_out_last;
  assign m00_axis.tuser  = w_out_user;

endmodule

`default_nettype wire

// File: tb/tb_fm_discriminator.sv
// ============================================================================
//  Module      : tb_fm_discriminator
//  Description : Directed scoreboard bench for fm_discriminator (NUM_CH = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fm_discriminator;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int SHIFT  = 4;
`ifdef FMD_DEEMPH_EN
  localparam int LAT    = 2;
`else
  localparam int LAT    = 1;
`endif

  typedef struct {
    logic [31:0]     data;
    logic [CH_W-1:0] user;
    logic            last;
    logic [3:0]      strb;
    int              acc_cyc;
    bit              chk_lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] thresh = 16'h0000;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  exp_t        q[$];
  logic [15:0] m_prev   [NUM_CH];
  bit          m_primed [NUM_CH];
  longint      m_y      [NUM_CH];
  int          m_ch = 0;
  bit          conv_mode = 1'b0;
  int          conv_last = 0;

  fm_discriminator_if #(.DATA_W(32), .USER_W(CH_W)) s_if ();
  fm_discriminator_if #(.DATA_W(32), .USER_W(CH_W)) m_if ();

  fm_discriminator #(.NUM_CH(NUM_CH)) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis        (s_if),
    .m00_axis        (m_if),
    .squelch_thresh  (thresh)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_prev[i]   = 16'h0000;
      m_primed[i] = 1'b0;
      m_y[i]      = 0;
    end
    m_ch = 0;
  endtask

  function automatic logic [31:0] model_out(input int ch, input logic [15:0] d);
    logic [15:0] t;
`ifdef FMD_DEEMPH_EN
    longint x;
    x      = longint'($signed(d)) * (longint'(1) << SHIFT);
    m_y[ch] = m_y[ch] + ((x - m_y[ch]) >>> SHIFT);
    t      = 16'(m_y[ch] >>> SHIFT);
`else
    t      = d;
`endif
    return {{16{t[15]}}, t};
  endfunction

  // Presents one sample, waits for its handshake and pushes the expectation.
  task automatic send(input logic [15:0] ang, input logic [15:0] mag, input bit last,
                      input bit use_exp, input logic [15:0] exp_d, input bit chk_lat);
    logic [15:0] d;
    exp_t        e;
    int          waited;
    s_if.tvalid = 1'b1;
    s_if.tdata  = {ang, mag};
    s_if.tlast  = last;
    s_if.tstrb  = ang[7:4] ^ 4'h5;
    waited      = 0;
    @(negedge clk);
    while (!s_if.tready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!s_if.tready) begin
      check("accept_timeout", {31'd0, s_if.tready}, 32'd1);
      s_if.tvalid = 1'b0;
      return;
    end
    d = (!m_primed[m_ch] || (mag < thresh)) ? 16'h0000 : ang - m_prev[m_ch];
    if (use_exp) d = exp_d;
    m_prev[m_ch]   = ang;
    m_primed[m_ch] = 1'b1;
    e.data    = model_out(m_ch, d);
    e.user    = CH_W'(m_ch);
    e.last    = last;
    e.strb    = ang[7:4] ^ 4'h5;
    e.acc_cyc = cyc;
    e.chk_lat = chk_lat;
    q.push_back(e);
    m_ch = (last || m_ch == NUM_CH - 1) ? 0 : m_ch + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_if.tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int waited;
    s_if.tvalid = 1'b0;
    waited = 0;
    while (q.size() != 0 && waited < 300) begin
      waited++;
      @(posedge clk);
    end
    #1;
    check("drain_left", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    s_if.tvalid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    model_reset();
    rst = 1'b0;
  endtask

  // Output monitor: pops the scoreboard on each transfer and checks hold stability.
  initial begin
    bit          held_v;
    logic [31:0] held_data;
    logic [CH_W-1:0] held_user;
    logic        held_last;
    logic [3:0]  held_strb;
    exp_t        e;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("hold_tdata", m_if.tdata, held_data);
          check("hold_tuser", 32'(m_if.tuser), 32'(held_user));
          check("hold_tlast", 32'(m_if.tlast), 32'(held_last));
          check("hold_tstrb", 32'(m_if.tstrb), 32'(held_strb));
        end
        if (m_if.tvalid && m_if.tready) begin
          if (q.size() == 0) begin
            check("unexpected_output", 32'(m_if.tvalid), 32'd0);
          end else begin
            e = q.pop_front();
            check("tdata", m_if.tdata, e.data);
            check("tuser", 32'(m_if.tuser), 32'(e.user));
            check("tlast", 32'(m_if.tlast), 32'(e.last));
            check("tstrb", 32'(m_if.tstrb), 32'(e.strb));
            if (e.chk_lat) check("latency", 32'(cyc - e.acc_cyc), 32'(LAT));
            if (conv_mode) begin
              check("deemph_monotonic", 32'($signed(m_if.tdata) >= conv_last), 32'd1);
              conv_last = $signed(m_if.tdata);
            end
          end
        end
        held_v    = m_if.tvalid && !m_if.tready;
        held_data = m_if.tdata;
        held_user = m_if.tuser;
        held_last = m_if.tlast;
        held_strb = m_if.tstrb;
      end
    end
  end

  initial begin
    logic [15:0] p;
    s_if.tvalid = 1'b0;
    s_if.tdata  = 32'h0;
    s_if.tstrb  = 4'h0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = '0;
    m_if.tready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_m_tdata",  m_if.tdata,       32'd0);
    check("rst_m_tuser",  32'(m_if.tuser),  32'd0);
    check("rst_m_tlast",  32'(m_if.tlast),  32'd0);
    check("rst_m_tstrb",  32'(m_if.tstrb),  32'd0);
    check("rst_s_tready", 32'(s_if.tready), 32'd1);
    @(posedge clk);
    #1;

    // Single channel (tlast every sample keeps channel 0), back-to-back.
    send(16'h0000, 16'h2000, 1'b1, 1'b1, 16'h0000, 1'b0);
    send(16'h0100, 16'h2000, 1'b1, 1'b1, 16'h0100, 1'b1);
    send(16'h0300, 16'h2000, 1'b1, 1'b1, 16'h0200, 1'b0);
    send(16'hFF00, 16'h2000, 1'b1, 1'b1, 16'hFC00, 1'b0);
    send(16'h0100, 16'h2000, 1'b1, 1'b1, 16'h0200, 1'b0);
    send(16'hFF00, 16'h2000, 1'b1, 1'b1, 16'hFE00, 1'b0);
    send(16'h0000, 16'h2000, 1'b1, 1'b1, 16'h0100, 1'b0);
    send(16'h8000, 16'h2000, 1'b1, 1'b1, 16'h8000, 1'b0);
    drain();

    // Four-channel interleave from a clean reset.
    do_reset();
    for (int c = 0; c < NUM_CH; c++)
      send(16'(16'h1000 * c), 16'h2000, c == NUM_CH - 1, 1'b1, 16'h0000, 1'b0);
    for (int c = 0; c < NUM_CH; c++)
      send(16'(16'h1000 * c + 16'h10 * (c + 1)), 16'h2000, c == NUM_CH - 1,
           1'b1, 16'(16'h10 * (c + 1)), 1'b0);

    // Backpressure mid-stream against the golden model.
    fork
      begin
        for (int i = 0; i < 16; i++)
          send(16'($urandom), 16'h2000, m_ch == NUM_CH - 1, 1'b0, 16'h0000, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        m_if.tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_s_tready", 32'(s_if.tready), 32'd0);
          check("bp_m_tvalid", 32'(m_if.tvalid), 32'd1);
        end
        @(posedge clk);
        #1;
        m_if.tready = 1'b1;
      end
    join
    drain();

    // Squelch, including magnitude exactly at the threshold.
    idle(2);
    thresh = 16'h1000;
    p = m_prev[0];
    send(p + 16'h0400, 16'h0800, 1'b1, 1'b1, 16'h0000, 1'b0);
    send(p + 16'h0800, 16'h2000, 1'b1, 1'b1, 16'h0400, 1'b0);
    send(p + 16'h0C00, 16'h1000, 1'b1, 1'b1, 16'h0400, 1'b0);
    drain();
    thresh = 16'h0000;

    // Reset with a sample stuck in the output stage.
    m_if.tready = 1'b0;
    send(16'h4444, 16'h2000, 1'b1, 1'b0, 16'h0000, 1'b0);
    idle(2);
    do_reset();
    m_if.tready = 1'b1;
    @(negedge clk);
    check("midrst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    @(posedge clk);
    #1;
    send(16'h1234, 16'h2000, 1'b1, 1'b1, 16'h0000, 1'b0);
    send(16'h1334, 16'h2000, 1'b1, 1'b1, 16'h0100, 1'b0);
    drain();

`ifdef FMD_DEEMPH_EN
    // Constant d = 0x1000 step response of the de-emphasis filter.
    do_reset();
    conv_mode = 1'b1;
    conv_last = 0;
    for (int k = 0; k < 200; k++)
      send(16'(16'h1000 * k), 16'h2000, 1'b1, 1'b0, 16'h0000, 1'b0);
    drain();
    conv_mode = 1'b0;
    check("deemph_final", 32'((conv_last >= 32'h0FFF) && (conv_last <= 32'h1000)), 32'd1);
`endif

    idle(4);
    check("final_queue", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
